display_scheduler: RTL and testbench

- Controller that decides what the two-digit BCD seven-segment display shows during a game, and when it is blanked.
- Owns the BCD score register and time-multiplexes the display between the countdown timer and the score.
- Forces the score onto the display on every hit, and blinks the final score after game over.
- disp_bcd and blank feed the display mux/driver; the multiplex clock is the same clk_1k (1 cycle = 1 ms).

---
 rtl/display_scheduler.sv | 179 +++++++++++++++++
 tb/tb_display_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : display_scheduler
// Purpose  : Chooses what the two-digit BCD display shows (time/score) and
//            when it is blanked; owns the BCD score register.
// Revision : 1.0
// ============================================================================
module display_scheduler #(
    parameter int DWELL_MS = 1000,
    parameter int HOLD_MS  = 500,
    parameter int BLINK_MS = 250
) (
    input  logic       clk_1k,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       game_over,
    input  logic [7:0] time_bcd,
    output logic [7:0] disp_bcd,
    output logic       blank,
    output logic [7:0] score_bcd,
    output logic [1:0] state
);

    localparam int DWELL_W = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int HOLD_W  = $clog2(HOLD_MS + 1);
    localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_MS);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          score_q, score_d;
    logic [7:0]          disp_q, disp_d;
    logic                blank_q, blank_d;
    logic                show_time_q, show_time_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;

    // Saturating two-digit BCD increment
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            score_q     <= 8'h00;
            disp_q      <= 8'h00;
            blank_q     <= 1'b0;
            show_time_q <= 1'b0;
            dwell_q     <= '0;
            hold_q      <= '0;
            blink_q     <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            disp_q      <= disp_d;
            blank_q     <= blank_d;
            show_time_q <= show_time_d;
            dwell_q     <= dwell_d;
            hold_q      <= hold_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        disp_d      = disp_q;
        blank_d     = blank_q;
        show_time_d = show_time_q;
        dwell_d     = dwell_q;
        hold_d      = hold_q;
        blink_d     = blink_q;

        case (state_q)
            S_IDLE: begin
                disp_d  = score_q;
                blank_d = 1'b0;
                if (start) begin
                    state_d     = S_PLAY;
                    score_d     = 8'h00;
                    show_time_d = 1'b1;
                    dwell_d     = '0;
                    hold_d      = '0;
                    blink_d     = '0;
                end
            end

            S_PLAY: begin
                disp_d  = show_time_q ? time_bcd : score_q;
                blank_d = 1'b0;
                if (start) begin
                    score_d     = 8'h00;
                    show_time_d = 1'b1;
                    dwell_d     = '0;
                    hold_d      = '0;
                    blink_d     = '0;
                end else begin
                    if (hit) begin
                        score_d     = bcd_inc(score_q);
                        show_time_d = 1'b0;
                        hold_d      = HOLD_LOAD;
                        dwell_d     = '0;
                    end else if (hold_q != '0) begin
                        // Hold expiry hands the display back to the timer
                        hold_d = hold_q - HOLD_ONE;
                        if (hold_q == HOLD_ONE) begin
                            show_time_d = 1'b1;
                            dwell_d     = '0;
                        end
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d     = '0;
                        show_time_d = ~show_time_q;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end

                    if (game_over || (time_bcd == 8'h00)) begin
                        state_d = S_OVER;
                        blink_d = '0;
                        blank_d = 1'b0;
                        hold_d  = '0;
                        dwell_d = '0;
                    end
                end
            end

            S_OVER: begin
                disp_d = score_q;
                if (start) begin
                    state_d     = S_PLAY;
                    score_d     = 8'h00;
                    show_time_d = 1'b1;
                    dwell_d     = '0;
                    hold_d      = '0;
                    blink_d     = '0;
                    blank_d     = 1'b0;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    blank_d = ~blank_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                blank_d = 1'b0;
            end
        endcase
    end

    assign disp_bcd  = disp_q;
    assign blank     = blank_q;
    assign score_bcd = score_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_display_scheduler
// Purpose  : Directed self-checking bench for display_scheduler.
// Revision : 1.0
// ============================================================================
module tb_display_scheduler;

    logic       clk_1k = 1'b0;
    logic       rst_n;
    logic       start;
    logic       hit;
    logic       game_over;
    logic [7:0] time_bcd;
    logic [7:0] disp_bcd;
    logic       blank;
    logic [7:0] score_bcd;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] ST_IDLE = 8'h00;
    localparam logic [7:0] ST_PLAY = 8'h01;
    localparam logic [7:0] ST_OVER = 8'h02;

    display_scheduler dut (
        .clk_1k    (clk_1k),
        .rst_n     (rst_n),
        .start     (start),
        .hit       (hit),
        .game_over (game_over),
        .time_bcd  (time_bcd),
        .disp_bcd  (disp_bcd),
        .blank     (blank),
        .score_bcd (score_bcd),
        .state     (state)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1k);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] exp_seq [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        hit       = 1'b0;
        game_over = 1'b0;
        time_bcd  = 8'h30;
        ticks(3);
        check("rst_state", {6'b0, state}, ST_IDLE);
        check("rst_score", score_bcd, 8'h00);
        check("rst_disp",  disp_bcd,  8'h00);
        check("rst_blank", {7'b0, blank}, 8'h00);
        rst_n = 1'b1;
        ticks(2);

        // Dwell alternation: 1000 cycles time, 1000 cycles score
        pulse_start();
        check("start_state", {6'b0, state}, ST_PLAY);
        check("start_score", score_bcd, 8'h00);
        tick();
        check("dwell_t_first", disp_bcd, 8'h30);
        ticks(999);
        check("dwell_t_last", disp_bcd, 8'h30);
        tick();
        check("dwell_s_first", disp_bcd, 8'h00);
        ticks(999);
        check("dwell_s_last", disp_bcd, 8'h00);
        tick();
        check("dwell_t_again", disp_bcd, 8'h30);

        // Twelve hits, 10 cycles apart
        for (int i = 0; i < 12; i++) begin
            pulse_hit();
            check("hit_score", score_bcd, exp_seq[i]);
            tick();
            check("hit_disp", disp_bcd, exp_seq[i]);
            if (i < 11) ticks(8);
        end
        ticks(499);
        check("hold_last", disp_bcd, 8'h12);
        tick();
        check("hold_release", disp_bcd, 8'h30);

        // Saturation at 99
        for (int i = 0; i < 86; i++) begin
            pulse_hit();
            tick();
        end
        check("score_98", score_bcd, 8'h98);
        pulse_hit();
        check("sat_1", score_bcd, 8'h99);
        tick();
        pulse_hit();
        check("sat_2", score_bcd, 8'h99);
        tick();
        pulse_hit();
        check("sat_3", score_bcd, 8'h99);

        // Time expiry, blink, hit ignored in OVER
        time_bcd = 8'h00;
        tick();
        check("over_state", {6'b0, state}, ST_OVER);
        tick();
        check("over_disp", disp_bcd, 8'h99);
        pulse_hit();
        check("over_hit_ignored", score_bcd, 8'h99);
        ticks(247);
        check("blink_lit_end", {7'b0, blank}, 8'h00);
        tick();
        check("blink_dark_start", {7'b0, blank}, 8'h01);
        ticks(249);
        check("blink_dark_end", {7'b0, blank}, 8'h01);
        tick();
        check("blink_lit_again", {7'b0, blank}, 8'h00);

        // hit together with game_over
        time_bcd = 8'h45;
        pulse_start();
        check("restart_state", {6'b0, state}, ST_PLAY);
        check("restart_score", score_bcd, 8'h00);
        for (int i = 0; i < 5; i++) begin
            pulse_hit();
            tick();
        end
        check("score_05", score_bcd, 8'h05);
        hit       = 1'b1;
        game_over = 1'b1;
        tick();
        hit       = 1'b0;
        game_over = 1'b0;
        check("hit_go_score", score_bcd, 8'h06);
        check("hit_go_state", {6'b0, state}, ST_OVER);
        ticks(300);
        check("over_dark", {7'b0, blank}, 8'h01);
        pulse_start();
        check("over_start_score", score_bcd, 8'h00);
        check("over_start_state", {6'b0, state}, ST_PLAY);
        check("over_start_blank", {7'b0, blank}, 8'h00);

        // Asynchronous reset mid-hold
        for (int i = 0; i < 42; i++) begin
            pulse_hit();
            tick();
        end
        check("score_42", score_bcd, 8'h42);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", {6'b0, state}, ST_IDLE);
        check("arst_score", score_bcd, 8'h00);
        check("arst_disp",  disp_bcd,  8'h00);
        check("arst_blank", {7'b0, blank}, 8'h00);
        tick();
        rst_n    = 1'b1;
        time_bcd = 8'h30;
        tick();
        pulse_start();
        check("rs_state", {6'b0, state}, ST_PLAY);
        tick();
        check("rs_disp_t", disp_bcd, 8'h30);
        ticks(999);
        check("rs_disp_t_last", disp_bcd, 8'h30);
        tick();
        check("rs_disp_s", disp_bcd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
